// File: rtl/pc_sequencer_if.sv
// Instruction-memory bus between the fetch sequencer (master) and memory (slave).
//   req   : fetch request, address valid
//   addr  : fetch address
//   ack   : memory accepts the request and returns rdata in the same cycle
//   rdata : fetched instruction word
interface pc_sequencer_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: drives the PC register, issues instruction fetches,
// delivers fetched instructions to decode and handles branch redirects.
// Optional feature macro: PCSEQ_EXC_EN adds the exception port (exc_req) and saved PC (epc).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pc_in                   current PC from the program counter register
//   pc_write, next_pc       PC register load strobe and value
//   stall                   blocks issue of new fetches
//   branch_valid/_target    one-cycle redirect request
//   exc_req, epc            exception request / saved PC (PCSEQ_EXC_EN only)
//   imem                    instruction-memory bus (master side)
//   fetch_valid, instr, fetch_pc  instruction delivered to decode
// All outputs except epc are combinational from state and inputs.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc_in,
    output logic                  pc_write,
    output logic [31:0]           next_pc,
    input  logic                  stall,
    input  logic                  branch_valid,
    input  logic [31:0]           branch_target,
`ifdef PCSEQ_EXC_EN
    input  logic                  exc_req,
    output logic [31:0]           epc,
`endif
    pc_sequencer_if.master        imem,
    output logic                  fetch_valid,
    output logic [31:0]           instr,
    output logic [31:0]           fetch_pc
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {BOOT, ISSUE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic        pend_exc_q, pend_exc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] addr_q, addr_d;

    logic        exc;
    logic [31:0] br_tgt;
    logic [31:0] exc_tgt;
    logic        redirect;
    logic [31:0] redirect_tgt;

`ifdef PCSEQ_EXC_EN
    assign exc = exc_req;
`else
    assign exc = 1'b0;
`endif

    // Redirect selection: exception > branch this cycle > pending target.
    assign br_tgt       = branch_target & ALIGN_MASK;
    assign exc_tgt      = EXC_VECTOR & ALIGN_MASK;
    assign redirect     = exc | branch_valid | pend_q;
    assign redirect_tgt = exc ? exc_tgt : (branch_valid ? br_tgt : pend_tgt_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pend_q     <= 1'b0;
            pend_exc_q <= 1'b0;
            pend_tgt_q <= 32'd0;
            addr_q     <= RESET_VECTOR;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_exc_q <= pend_exc_d;
            pend_tgt_q <= pend_tgt_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_exc_d  = pend_exc_q;
        pend_tgt_d  = pend_tgt_q;
        addr_d      = addr_q;
        pc_write    = 1'b0;
        next_pc     = 32'd0;
        imem.req    = 1'b0;
        imem.addr   = 32'd0;
        fetch_valid = 1'b0;
        instr       = 32'd0;
        fetch_pc    = 32'd0;

        case (state_q)
            BOOT: begin
                pc_write = 1'b1;
                next_pc  = RESET_VECTOR;
                state_d  = ISSUE;
            end
            ISSUE: begin
                if (redirect) begin
                    pc_write   = 1'b1;
                    next_pc    = redirect_tgt;
                    pend_d     = 1'b0;
                    pend_exc_d = 1'b0;
                end else if (!stall) begin
                    imem.req  = 1'b1;
                    imem.addr = pc_in;
                    if (imem.ack) begin
                        pc_write    = 1'b1;
                        next_pc     = pc_in + PC_STEP;
                        fetch_valid = 1'b1;
                        instr       = imem.rdata;
                        fetch_pc    = pc_in;
                    end else begin
                        addr_d  = pc_in;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Request stays up until accepted; stall cannot retract it.
                imem.req  = 1'b1;
                imem.addr = addr_q;
                if (imem.ack) begin
                    pc_write    = 1'b1;
                    next_pc     = redirect ? redirect_tgt : addr_q + PC_STEP;
                    fetch_valid = !redirect;
                    instr       = redirect ? 32'd0 : imem.rdata;
                    fetch_pc    = redirect ? 32'd0 : addr_q;
                    pend_d      = 1'b0;
                    pend_exc_d  = 1'b0;
                    state_d     = ISSUE;
                end else if (exc) begin
                    pend_d     = 1'b1;
                    pend_exc_d = 1'b1;
                    pend_tgt_d = exc_tgt;
                end else if (branch_valid && !pend_exc_q) begin
                    // Latest branch wins, but never displaces a pending exception.
                    pend_d     = 1'b1;
                    pend_tgt_d = br_tgt;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (!rst_n) begin
            pc_write    = 1'b0;
            next_pc     = 32'd0;
            imem.req    = 1'b0;
            imem.addr   = 32'd0;
            fetch_valid = 1'b0;
            instr       = 32'd0;
            fetch_pc    = 32'd0;
        end
    end

`ifdef PCSEQ_EXC_EN
    logic [31:0] epc_q, epc_d;

    // epc captures the PC the sequencer would have used had the exception not arrived.
    always_comb begin
        epc_d = epc_q;
        if (exc_req && !pend_exc_q) begin
            case (state_q)
                ISSUE:   epc_d = branch_valid ? br_tgt : (pend_q ? pend_tgt_q : pc_in);
                WAIT:    epc_d = branch_valid ? br_tgt :
                                 (pend_q ? pend_tgt_q : (imem.ack ? addr_q + PC_STEP : addr_q));
                default: epc_d = epc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q <= 32'd0;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc = epc_q;
`endif

endmodule
